// File: rtl/led7seg_scan_if.sv
// rtl/led7seg_scan_if.sv - display bus between the register/data path and led7seg_scan
interface led7seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                load;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic [7:0]          LED;
  logic [DIGITS-1:0]   SA;
  logic                frame;

  modport master (output load, data, dp, blank, input LED, SA, frame);
  modport slave  (input load, data, dp, blank, output LED, SA, frame);
endinterface

// File: rtl/led7seg_scan.sv
// rtl/led7seg_scan.sv - double-buffered multiplexed N-digit seven-segment scanner
// Optional leading-zero blanking: define LED7SEG_LZB_EN.
module led7seg_scan #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  led7seg_scan_if.slave  bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pend_data, r_act_data;
  logic [DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [DIGITS-1:0]   r_pend_blank, r_act_blank;
  logic                r_pend_v;
  logic [7:0]          r_led;
  logic [DIGITS-1:0]   r_sa;
  logic                r_frame;

  logic                w_tick, w_wrap;
  logic [3:0]          w_nib;
  logic                w_dp_sel, w_blank_sel;
  logic [DIGITS-1:0]   w_sup;
  logic [DIGITS-1:0]   w_sa_nxt;
  logic [7:0]          w_led_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;  4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;  4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;  4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;  4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;  4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;  4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;  4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;  default: seg_decode = 7'h71;
    endcase
  endfunction

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_MAX);

`ifdef LED7SEG_LZB_EN
  logic w_lead;
  // Walk from the most significant digit; suppression stops at the first visible content.
  always_comb begin
    w_sup  = '0;
    w_lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (w_lead && (r_act_data[4*i +: 4] == 4'h0) && !r_act_dp[i]) begin
        w_sup[i] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  assign w_sup = '0;
`endif

  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_sa_nxt    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_act_data[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_blank_sel = r_act_blank[i] | w_sup[i];
        // First cycle of each slot keeps all selects off so the segment change cannot ghost.
        w_sa_nxt[i] = (r_cnt != '0);
      end
    end
    w_led_nxt = w_blank_sel ? 8'h00 : {w_dp_sel, seg_decode(w_nib)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_v     <= 1'b0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_led        <= 8'h00;
      r_sa         <= '0;
      r_frame      <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
      end
      if (bus.load && w_wrap) begin
        r_act_data  <= bus.data;
        r_act_dp    <= bus.dp;
        r_act_blank <= bus.blank;
        r_pend_v    <= 1'b0;
      end else if (bus.load) begin
        r_pend_data  <= bus.data;
        r_pend_dp    <= bus.dp;
        r_pend_blank <= bus.blank;
        r_pend_v     <= 1'b1;
      end else if (w_wrap && r_pend_v) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
        r_pend_v    <= 1'b0;
      end
      r_led   <= w_led_nxt;
      r_sa    <= w_sa_nxt;
      r_frame <= w_wrap;
    end
  end

  assign bus.LED   = r_led;
  assign bus.SA    = r_sa;
  assign bus.frame = r_frame;
endmodule

// File: tb/tb_led7seg_scan.sv
// tb/tb_led7seg_scan.sv - directed self-checking bench for led7seg_scan
module tb_led7seg_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef LED7SEG_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  led7seg_scan_if #(.DIGITS(4)) bus  ();
  led7seg_scan_if #(.DIGITS(1)) bus1 ();

  led7seg_scan #(.DIGITS(4), .CLK_DIV(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  led7seg_scan #(.DIGITS(1), .CLK_DIV(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [3:0] sa_tab [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                              4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask

  task automatic goto(input int t);
    while (k < t) adv(1);
  endtask

  task automatic load_vec(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.load  = 1'b1;
    bus.data  = d;
    bus.dp    = p;
    bus.blank = b;
    adv(1);
    bus.load  = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0;  bus.data = '0;  bus.dp = '0;  bus.blank = '0;
    bus1.load = 1'b0; bus1.data = '0; bus1.dp = '0; bus1.blank = '0;

    repeat (3) @(negedge clk);
    chk("rst_led", bus.LED, 8'h00);
    chk("rst_sa", {4'h0, bus.SA}, 8'h00);
    chk("rst_frame", {7'h0, bus.frame}, 8'h00);

    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 16; i++) begin
      adv(1);
      chk("scan_sa", {4'h0, bus.SA}, {4'h0, sa_tab[i-1]});
      chk("scan_frame", {7'h0, bus.frame}, (i == 16) ? 8'h01 : 8'h00);
      chk("d1_sa", {7'h0, bus1.SA}, (i % 2 == 0) ? 8'h01 : 8'h00);
      chk("d1_frame", {7'h0, bus1.frame}, (i % 2 == 0) ? 8'h01 : 8'h00);
      chk("d1_led", bus1.LED, 8'h3F);
    end

    load_vec(16'h1A3F, 4'b0010, 4'b0000);
    goto(30); chk("dec_before_wrap", bus.LED, 8'h3F);
    goto(31); chk("frame_low", {7'h0, bus.frame}, 8'h00);
    goto(32); chk("frame_period", {7'h0, bus.frame}, 8'h01);
    goto(34); chk("dec_d0", bus.LED, 8'h71); chk("dec_sa0", {4'h0, bus.SA}, 8'h01);
    goto(38); chk("dec_d1_dp", bus.LED, 8'hCF); chk("dec_sa1", {4'h0, bus.SA}, 8'h02);
    goto(42); chk("dec_d2", bus.LED, 8'h77); chk("dec_sa2", {4'h0, bus.SA}, 8'h04);
    goto(46); chk("dec_d3", bus.LED, 8'h06); chk("dec_sa3", {4'h0, bus.SA}, 8'h08);

    goto(48); load_vec(16'h1234, 4'b0000, 4'b0000);
    goto(50); chk("dbuf_old_d0", bus.LED, 8'h71);
    goto(52); load_vec(16'h5678, 4'b0000, 4'b0000);
    goto(62); chk("dbuf_old_d3", bus.LED, 8'h06);
    goto(66); chk("dbuf_d0", bus.LED, 8'h7F);
    goto(70); chk("dbuf_d1", bus.LED, 8'h07);
    goto(72); load_vec(16'h9999, 4'b0000, 4'b0000);
    goto(74); chk("dbuf_d2", bus.LED, 8'h7D);
    goto(78); chk("dbuf_d3", bus.LED, 8'h6D);

    goto(79); load_vec(16'hBEEF, 4'b0000, 4'b0000);
    goto(82); chk("sim_d0", bus.LED, 8'h71);
    goto(86); chk("sim_d1", bus.LED, 8'h79);
    goto(90); chk("sim_d2", bus.LED, 8'h79);
    goto(94); chk("sim_d3", bus.LED, 8'h7C);
    goto(98); chk("sim_pend_cleared", bus.LED, 8'h71);

    goto(111); load_vec(16'h0070, 4'b0000, 4'b0000);
    goto(114); chk("lzb_d0", bus.LED, 8'h3F);
    goto(118); chk("lzb_d1", bus.LED, 8'h07);
    goto(122); chk("lzb_d2", bus.LED, LZB ? 8'h00 : 8'h3F); chk("lzb_sa2", {4'h0, bus.SA}, 8'h04);
    goto(126); chk("lzb_d3", bus.LED, LZB ? 8'h00 : 8'h3F);

    goto(127); load_vec(16'h0070, 4'b0100, 4'b0100);
    goto(130); chk("blank_d0", bus.LED, 8'h3F);
    goto(138); chk("blank_d2", bus.LED, 8'h00); chk("blank_sa2", {4'h0, bus.SA}, 8'h04);
    goto(142); chk("blank_d3", bus.LED, LZB ? 8'h00 : 8'h3F);

    goto(143); load_vec(16'h0123, 4'b0000, 4'b0000);
    goto(150); load_vec(16'hFFFF, 4'b0000, 4'b0000);
    goto(154); chk("pre_rst_led", bus.LED, 8'h06); chk("pre_rst_sa", {4'h0, bus.SA}, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", bus.LED, 8'h00);
    chk("async_rst_sa", {4'h0, bus.SA}, 8'h00);
    chk("async_rst_frame", {7'h0, bus.frame}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    goto(1);  chk("restart_sa_k1", {4'h0, bus.SA}, 8'h00);
    goto(2);  chk("restart_sa_k2", {4'h0, bus.SA}, 8'h01); chk("restart_led", bus.LED, 8'h3F);
    goto(18); chk("pend_discarded", bus.LED, 8'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
